// File: rtl/restoring_divider_8bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Contains the 8-bit ripple subtractor used for each trial subtraction.

module full_subtractor_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Bin,
  output logic [7:0] Diff,
  output logic       Bout
);

  assign {Bout, Diff} = {1'b0, A} - {1'b0, B} - {8'd0, Bin};

endmodule

module restoring_divider_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] r_q, r_d;
  logic [7:0] q_q, q_d;
  logic [7:0] d_q, d_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] quotient_q, quotient_d;
  logic [7:0] remainder_q, remainder_d;
  logic       dbz_q, dbz_d;

  logic [7:0] trial;
  logic [7:0] diff;
  logic       bout;
  logic       qb;

  // Low 8 bits of the 9-bit trial remainder; r_q[7] is the implicit 9th bit.
  assign trial = {r_q[6:0], q_q[7]};

  full_subtractor_8bit u_sub (
    .A    (trial),
    .B    (d_q),
    .Bin  (1'b0),
    .Diff (diff),
    .Bout (bout)
  );

  assign qb = r_q[7] | ~bout;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      StRun: begin
        r_d   = qb ? diff : trial;
        q_d   = {q_q[6:0], qb};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          state_d     = StDone;
          quotient_d  = q_d;
          remainder_d = r_d;
        end
      end
      default: begin
        // Idle and Done both accept a new request, enabling back-to-back operation.
        state_d = StIdle;
        if (start) begin
          if (divisor != 8'd0) begin
            state_d = StRun;
            r_d     = 8'd0;
            q_d     = dividend;
            d_d     = divisor;
            cnt_d   = 4'd0;
            dbz_d   = 1'b0;
          end else begin
            state_d     = StDone;
            quotient_d  = 8'hFF;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      r_q         <= 8'd0;
      q_q         <= 8'd0;
      d_q         <= 8'd0;
      cnt_q       <= 4'd0;
      quotient_q  <= 8'd0;
      remainder_q <= 8'd0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// Directed and randomised checks of restoring_divider_8bit: results, latency, handshake,
// divide-by-zero, ignored starts, back-to-back operation and asynchronous reset.

module tb_restoring_divider_8bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_vec;
  int n_miss;

  restoring_divider_8bit #(
    .WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge just after the edge that samples start.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // c0 is the number of falling edges already seen since the sampling edge (inclusive).
  task automatic wait_done(input int c0, input int lat, input string tag);
    int c;
    c = c0;
    while (!done && c < 20) begin
      chk({tag, " busy"}, busy, 1'b1);
      @(negedge clk);
      c++;
    end
    chk({tag, " latency"}, c, lat);
    chk({tag, " busy at done"}, busy, 1'b0);
  endtask

  task automatic chk_res(input string tag, input logic [7:0] q, input logic [7:0] r,
                         input logic z);
    chk({tag, " quotient"}, quotient, q);
    chk({tag, " remainder"}, remainder, r);
    chk({tag, " div_by_zero"}, div_by_zero, z);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    n_vec    = 0;
    n_miss   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk_res("reset", 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 100/7 with done-pulse width check
    issue(8'd100, 8'd7);
    wait_done(1, 9, "100/7");
    chk_res("100/7", 8'd14, 8'd2, 1'b0);
    @(negedge clk);
    chk("100/7 done pulse", done, 1'b0);

    issue(8'd255, 8'd1);
    wait_done(1, 9, "255/1");
    chk_res("255/1", 8'd255, 8'd0, 1'b0);
    issue(8'd200, 8'd201);
    wait_done(1, 9, "200/201");
    chk_res("200/201", 8'd0, 8'd200, 1'b0);
    issue(8'd255, 8'd128);
    wait_done(1, 9, "255/128");
    chk_res("255/128", 8'd1, 8'd127, 1'b0);

    // Divide by zero, then a normal op must clear the flag
    issue(8'd37, 8'd0);
    wait_done(1, 1, "37/0");
    chk_res("37/0", 8'hFF, 8'd37, 1'b1);
    @(negedge clk);
    chk("37/0 done pulse", done, 1'b0);
    chk("37/0 busy after", busy, 1'b0);
    issue(8'd9, 8'd3);
    wait_done(1, 9, "9/3");
    chk_res("9/3", 8'd3, 8'd0, 1'b0);

    // Start while busy is ignored; start in the done cycle is accepted
    issue(8'd100, 8'd7);
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(3, 9, "ignored start");
    chk_res("ignored start", 8'd14, 8'd2, 1'b0);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(1, 9, "back-to-back 50/5");
    chk_res("back-to-back 50/5", 8'd10, 8'd0, 1'b0);

    // Reset during the 4th run cycle aborts
    issue(8'd200, 8'd3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid-run reset busy", busy, 1'b0);
    chk("mid-run reset done", done, 1'b0);
    chk_res("mid-run reset", 8'd0, 8'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no done after abort", done, 1'b0);
    chk("quotient after abort", quotient, 8'd0);
    issue(8'd200, 8'd3);
    wait_done(1, 9, "200/3");
    chk_res("200/3", 8'd66, 8'd2, 1'b0);

    // Randomised operands against the language's own / and %
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      issue(a, b);
      wait_done(1, 9, "random");
      chk_res("random", a / b, a % b, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
